mult_product_accumulator: RTL and testbench



---
 rtl/mult_acc_pkg.sv | 13 +
 rtl/mult_acc_adder.sv | 32 +++
 rtl/mult_product_accumulator.sv | 101 ++++++++++
 tb/tb_mult_product_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// Shared constants for the product accumulator: FSM state encodings and default sizes.
package mult_acc_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 12;
    localparam int DEF_COUNT  = 4;

    typedef logic [0:0] mult_acc_state_t;

    localparam mult_acc_state_t ACCUM = 1'b0;
    localparam mult_acc_state_t HOLD  = 1'b1;

endpackage

// File: rtl/mult_acc_adder.sv
// Combinational accumulate adder with carry-out.
// With MULT_ACC_SAT_EN defined, a carry clamps the sum to the all-ones value instead of wrapping.
module mult_acc_adder
    import mult_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] product_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full_sum_s;

    // Widened add so the carry-out of the ACC_W adder is visible.
    always_comb begin
        full_sum_s = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, product_i};
        carry_o    = full_sum_s[ACC_W];
`ifdef MULT_ACC_SAT_EN
        if (full_sum_s[ACC_W]) begin
            sum_o = {ACC_W{1'b1}};
        end else begin
            sum_o = full_sum_s[ACC_W-1:0];
        end
`else
        sum_o = full_sum_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mult_product_accumulator.sv
// Frame accumulator: sums COUNT products, then holds the sum on a valid/ready output.
// Optional build macro MULT_ACC_SAT_EN selects saturating instead of wrapping arithmetic.
module mult_product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int COUNT  = DEF_COUNT,
    localparam int CNT_W = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    mult_acc_state_t  state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_s;
    logic             carry_s;

    mult_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_i     (acc_q),
        .product_i (product),
        .sum_o     (sum_s),
        .carry_o   (carry_s)
    );

    // Next-state logic; the adder result is only used on an accept in ACCUM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_s;
                    ovf_d = ovf_q | carry_s;
                    if (cnt_q == LAST_CNT) begin
                        state_d = HOLD;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = {ACC_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ACCUM;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State registers; clear drops any in-flight accept or held result exactly like rst.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= ACCUM;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench for mult_product_accumulator: default build plus a 10-bit, 8-deep instance
// for overflow; expectations follow MULT_ACC_SAT_EN when it is defined.
module tb_mult_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  product = 8'd0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, overflow;
    logic [11:0] acc_out;

    logic        o_clear = 1'b0;
    logic        o_in_valid = 1'b0;
    logic [7:0]  o_product = 8'd0;
    logic        o_out_ready = 1'b0;
    logic        o_in_ready, o_out_valid, o_overflow;
    logic [9:0]  o_acc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_product_accumulator u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow)
    );

    mult_product_accumulator #(.PROD_W(8), .ACC_W(10), .COUNT(8)) u_ovf (
        .clk       (clk),
        .rst       (rst),
        .clear     (o_clear),
        .in_valid  (o_in_valid),
        .in_ready  (o_in_ready),
        .product   (o_product),
        .out_valid (o_out_valid),
        .out_ready (o_out_ready),
        .acc_out   (o_acc_out),
        .overflow  (o_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] p);
        in_valid = 1'b1;
        product  = p;
        step();
        in_valid = 1'b0;
        product  = 8'hFF;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [11:0] exp_acc, input logic exp_ovf);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_acc"}, {20'd0, acc_out}, {20'd0, exp_acc});
        check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    logic [9:0] exp_ovf_acc;

    initial begin
        step();
        step();
        rst = 1'b0;

        // Reset then idle, with product toggling while in_valid is low
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_ready", {31'd0, in_ready}, 32'd1);
            check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
            check_eq("idle_acc", {20'd0, acc_out}, 32'd0);
            check_eq("idle_ovf", {31'd0, overflow}, 32'd0);
            product = 8'(i * 37);
            step();
        end

        // Basic frame, back-to-back, consumer late by 3 cycles
        in_valid = 1'b1;
        product = 8'd15;  step();
        product = 8'd30;  step();
        product = 8'd45;  step();
        product = 8'd225; step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_out("basic", 12'd315, 1'b0);
            step();
        end
        take();
        check_eq("basic_taken_valid", {31'd0, out_valid}, 32'd0);
        check_eq("basic_taken_acc", {20'd0, acc_out}, 32'd0);

        // Gapped input
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
            if (i < 4) step();
        end
        check_out("gap", 12'd10, 1'b0);

        // Product offered in the same cycle the sum is taken is not accepted
        out_ready = 1'b1;
        in_valid  = 1'b1;
        product   = 8'd9;
        step();
        out_ready = 1'b0;
        check_eq("nobypass_acc", {20'd0, acc_out}, 32'd0);
        check_eq("nobypass_ready", {31'd0, in_ready}, 32'd1);
        check_eq("nobypass_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("nextframe_acc", {20'd0, acc_out}, 32'd9);
        step(); step(); step();
        in_valid = 1'b0;
        check_out("nextframe", 12'd36, 1'b0);
        take();

        // Clear mid-frame discards the accept in the same cycle
        push(8'd100);
        push(8'd100);
        check_eq("preclear_acc", {20'd0, acc_out}, 32'd200);
        clear = 1'b1;
        push(8'd100);
        clear = 1'b0;
        check_eq("clear_acc", {20'd0, acc_out}, 32'd0);
        for (int i = 0; i < 4; i++) push(8'd5);
        check_out("postclear", 12'd20, 1'b0);
        take();

        // Overflow on the 10-bit, 8-deep instance
`ifdef MULT_ACC_SAT_EN
        exp_ovf_acc = 10'd1023;
`else
        exp_ovf_acc = 10'd776;
`endif
        o_in_valid = 1'b1;
        o_product  = 8'd225;
        for (int i = 0; i < 8; i++) step();
        o_in_valid = 1'b0;
        check_eq("ovf_valid", {31'd0, o_out_valid}, 32'd1);
        check_eq("ovf_acc", {22'd0, o_acc_out}, {22'd0, exp_ovf_acc});
        check_eq("ovf_flag", {31'd0, o_overflow}, 32'd1);
        o_out_ready = 1'b1;
        step();
        o_out_ready = 1'b0;
        check_eq("ovf_taken_flag", {31'd0, o_overflow}, 32'd0);
        o_in_valid = 1'b1;
        o_product  = 8'd1;
        for (int i = 0; i < 8; i++) step();
        o_in_valid = 1'b0;
        check_eq("ovf_next_acc", {22'd0, o_acc_out}, 32'd8);
        check_eq("ovf_next_flag", {31'd0, o_overflow}, 32'd0);
        check_eq("ovf_next_valid", {31'd0, o_out_valid}, 32'd1);

        // Reset while a result is held
        for (int i = 1; i <= 4; i++) push(8'(i));
        check_out("prerst", 12'd10, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rsthold_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rsthold_acc", {20'd0, acc_out}, 32'd0);
        check_eq("rsthold_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) push(8'd1);
        check_out("postrst", 12'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
